// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM states, prescale floor and majority helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int MIN_PRESCALE = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and 3-sample majority vote around mid-bit.
module uart_rx_sampler import uart_pkg::*; #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic                  i_rx,
    input  logic [PRESCALE_W-1:0] i_presc,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic                  o_vote,
    output logic                  o_vote_valid
);
    logic [PRESCALE_W-1:0] r_cnt;
    logic [PRESCALE_W-1:0] w_half;
    logic [1:0]            r_smp;
    logic                  r_vote;
    logic                  r_vote_valid;

    assign w_half = i_presc >> 1;

    // The vote is registered on the third sample, so it is valid at P/2+2.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_smp        <= '0;
            r_vote       <= 1'b0;
            r_vote_valid <= 1'b0;
        end else begin
            r_cnt        <= i_clr ? '0 : !i_en ? r_cnt :
                            (r_cnt == i_presc - PRESCALE_W'(1)) ? '0 : r_cnt + PRESCALE_W'(1);
            if (i_en && r_cnt == w_half - PRESCALE_W'(1)) r_smp[0] <= i_rx;
            if (i_en && r_cnt == w_half) r_smp[1] <= i_rx;
            if (i_en && r_cnt == w_half + PRESCALE_W'(1)) r_vote <= maj3(r_smp[0], r_smp[1], i_rx);
            r_vote_valid <= !i_clr && i_en && r_cnt == w_half + PRESCALE_W'(1);
        end

    assign o_edge_cnt   = r_cnt;
    assign o_vote       = r_vote;
    assign o_vote_valid = r_vote_valid;

endmodule

// File: rtl/uart_rx_gen.sv
// uart_rx_gen: parametrised UART receiver with majority voting, parity/stop error flags
// and a mid-stop return to idle for back-to-back frames.
module uart_rx_gen import uart_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    localparam int CW = $clog2(DATA_WIDTH);

    state_t                r_state, w_next;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] w_edge_cnt;
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic r_par_en, r_par_typ, r_stop2, r_first_stop, r_par_bad, r_stp_bad;
    logic r_valid, r_perr, r_serr;
    logic w_vote, w_dec, w_last, w_last_bit, w_run, w_clr;
    logic w_start, w_shift, w_chk_par, w_chk_stp, w_emit, w_stp_bad, w_good;

    assign w_last     = w_edge_cnt == r_presc - PRESCALE_W'(1);
    assign w_last_bit = r_bit_cnt == CW'(DATA_WIDTH - 1);
    assign w_run      = (r_state != IDLE) || !RX_IN;
    assign w_clr      = w_next == IDLE;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .i_clk        (CLK),
        .i_rst_n      (RST),
        .i_en         (w_run),
        .i_clr        (w_clr),
        .i_rx         (RX_IN),
        .i_presc      (r_presc),
        .o_edge_cnt   (w_edge_cnt),
        .o_vote       (w_vote),
        .o_vote_valid (w_dec)
    );

    always_ff @(posedge CLK or negedge RST)
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = RX_IN ? IDLE : START;
            START:   w_next = (w_dec && w_vote) ? IDLE : w_last ? DATA : START;
            DATA:    w_next = (w_last && w_last_bit) ? (r_par_en ? PARITY : STOP) : DATA;
            PARITY:  w_next = w_last ? STOP : PARITY;
            STOP:    w_next = w_emit ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_start   = (r_state == IDLE) && !RX_IN;
        w_shift   = (r_state == DATA) && w_dec;
        w_chk_par = (r_state == PARITY) && w_dec;
        w_chk_stp = (r_state == STOP) && w_dec;
        w_emit    = w_chk_stp && !(r_stop2 && r_first_stop);
        w_stp_bad = r_stp_bad | !w_vote;
        w_good    = !r_par_bad && !w_stp_bad;
    end

    // Frame configuration is frozen at the start bit; mid-frame input changes are ignored.
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            r_presc      <= PRESCALE_W'(MIN_PRESCALE);
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_stop2      <= 1'b0;
            r_first_stop <= 1'b0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bad    <= 1'b0;
            r_stp_bad    <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_perr       <= 1'b0;
            r_serr       <= 1'b0;
        end else begin
            if (w_start) begin
                r_presc      <= prescale;
                r_par_en     <= PAR_EN;
                r_par_typ    <= PAR_TYP;
                r_stop2      <= STOP2;
                r_first_stop <= 1'b1;
                r_bit_cnt    <= '0;
                r_par_bad    <= 1'b0;
                r_stp_bad    <= 1'b0;
            end
            if (r_state == DATA && w_last) r_bit_cnt <= r_bit_cnt + CW'(1);
            if (w_shift) r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
            if (w_chk_par) r_par_bad <= w_vote ^ (^r_shift) ^ r_par_typ;
            if (w_chk_stp) r_stp_bad <= w_stp_bad;
            if (r_state == STOP && w_last) r_first_stop <= 1'b0;
            if (w_emit && w_good) r_data <= r_shift;
            r_valid <= w_emit && w_good;
            r_perr  <= w_emit && r_par_bad;
            r_serr  <= w_emit && w_stp_bad;
        end

    assign P_DATA     = r_data;
    assign data_valid = r_valid;
    assign par_err    = r_perr;
    assign stp_err    = r_serr;

endmodule

// File: tb/tb_uart_rx_gen.sv
// tb_uart_rx_gen: directed frames with a queue scoreboard checking result pulses, timing and data.
module tb_uart_rx_gen;
    import uart_pkg::*;

    typedef struct {
        int         t;
        bit         v;
        bit         pe;
        bit         se;
        logic [8:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx8 = 1'b1;
    logic       rx5 = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stop2 = 1'b0;
    logic [5:0] presc = 6'd8;
    logic [7:0] p_data8;
    logic [4:0] p_data5;
    logic       dv8, pe8, se8, dv5, pe5, se5;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [8:0] lg8 = '0;
    logic [8:0] lg5 = '0;
    exp_t       q8[$];
    exp_t       q5[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_gen #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (
        .CLK(clk), .RST(rst_n), .RX_IN(rx8), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .prescale(presc), .P_DATA(p_data8), .data_valid(dv8),
        .par_err(pe8), .stp_err(se8)
    );

    uart_rx_gen #(.DATA_WIDTH(5), .PRESCALE_W(6)) dut5 (
        .CLK(clk), .RST(rst_n), .RX_IN(rx5), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .prescale(presc), .P_DATA(p_data5), .data_valid(dv5),
        .par_err(pe5), .stp_err(se5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic bit_out(input int w, input logic v, input int n);
        if (w == 5) rx5 = v;
        else        rx8 = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; the expected result (time, flags, P_DATA) is queued before the first bit.
    task automatic send(input int w, input logic [8:0] d, input int dw, input int p,
                        input bit pe, input bit pt, input bit bad_par, input bit s2,
                        input bit bad_stop, input bit short_stop, input int gl, input bit exp_out);
        int   t0, n;
        logic par;
        exp_t e;
        presc   = 6'(p);
        par_en  = pe;
        par_typ = pt;
        stop2   = s2;
        par     = pt ^ bad_par;
        for (int i = 0; i < dw; i++) par ^= d[i];
        n  = 2 + dw + int'(pe) + int'(s2);
        t0 = cyc + 1;
        if (exp_out) begin
            if (!bad_par && !bad_stop) begin
                if (w == 5) lg5 = d;
                else        lg8 = d;
            end
            e.t  = t0 + (n - 1) * p + p / 2 + 2;
            e.v  = !bad_par && !bad_stop;
            e.pe = bad_par;
            e.se = bad_stop;
            e.d  = (w == 5) ? lg5 : lg8;
            if (w == 5) q5.push_back(e);
            else        q8.push_back(e);
        end
        bit_out(w, 1'b0, p);
        for (int i = 0; i < dw; i++)
            if (i == gl) begin
                bit_out(w, d[i], p / 2);
                bit_out(w, !d[i], 1);
                bit_out(w, d[i], p / 2 - 1);
            end else bit_out(w, d[i], p);
        if (pe) bit_out(w, par, p);
        if (s2) bit_out(w, 1'b1, p);
        bit_out(w, !bad_stop, short_stop ? p / 2 + 3 : p);
    endtask

    always @(negedge clk)
        if (dv8 || pe8 || se8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected8: dv=%b pe=%b se=%b data=%0h at cycle %0d", dv8, pe8, se8, p_data8, cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("time8", 32'(cyc), 32'(e.t));
                chk("flags8", {29'b0, dv8, pe8, se8}, {29'b0, e.v, e.pe, e.se});
                chk("data8", 32'(p_data8), 32'(e.d));
            end
        end

    always @(negedge clk)
        if (dv5 || pe5 || se5) begin
            if (q5.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected5: dv=%b pe=%b se=%b data=%0h at cycle %0d", dv5, pe5, se5, p_data5, cyc);
            end else begin
                exp_t e;
                e = q5.pop_front();
                chk("time5", 32'(cyc), 32'(e.t));
                chk("flags5", {29'b0, dv5, pe5, se5}, {29'b0, e.v, e.pe, e.se});
                chk("data5", 32'(p_data5), 32'(e.d));
            end
        end

    initial begin
        int t0g;
        repeat (3) @(negedge clk);
        chk("rst_data8", 32'(p_data8), 32'h0);
        chk("rst_flags8", {29'b0, dv8, pe8, se8}, 32'h0);
        chk("rst_data5", 32'(p_data5), 32'h0);
        chk("rst_flags5", {29'b0, dv5, pe5, se5}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5, P=8, no parity, one stop: result at t0+78
        send(8, 9'hA5, 8, 8, 0, 0, 0, 0, 0, 0, -1, 1);
        bit_out(8, 1'b1, 4);
        // 0x3C, P=16, even parity with wrong parity bit 1: par_err, P_DATA stays 0xA5
        send(8, 9'h3C, 8, 16, 1, 0, 1, 0, 0, 0, -1, 1);
        bit_out(8, 1'b1, 4);
        // two stop bits, second driven low, then 0x55 starting on the very next cycle
        send(8, 9'h96, 8, 8, 0, 0, 0, 1, 1, 1, -1, 1);
        send(8, 9'h55, 8, 8, 0, 0, 0, 1, 0, 0, -1, 1);
        bit_out(8, 1'b1, 4);

        // two-cycle start glitch: START just before t0+6, IDLE at t0+6
        presc = 6'd8;
        stop2 = 1'b0;
        par_en = 1'b0;
        t0g = cyc + 1;
        bit_out(8, 1'b0, 2);
        bit_out(8, 1'b1, 4);
        chk("glitch_start", 32'(dut8.r_state), 32'(START));
        chk("glitch_cycle", 32'(cyc), 32'(t0g + 5));
        @(negedge clk);
        chk("glitch_idle", 32'(dut8.r_state), 32'(IDLE));
        bit_out(8, 1'b1, 3);
        send(8, 9'h0F, 8, 8, 0, 0, 0, 0, 0, 0, -1, 1);
        bit_out(8, 1'b1, 2);

        // single-cycle inverted glitch mid data bit 3 of 0xFF
        send(8, 9'hFF, 8, 8, 0, 0, 0, 0, 0, 0, 3, 1);
        bit_out(8, 1'b1, 2);

        // 5-bit build, odd parity, 0x1B
        send(5, 9'h1B, 5, 8, 1, 1, 0, 0, 0, 0, -1, 1);
        bit_out(5, 1'b1, 4);

        // prescale raised mid-frame: the frame still completes at P=8
        fork
            send(8, 9'h81, 8, 8, 0, 0, 0, 0, 0, 0, -1, 1);
            begin
                repeat (20) @(negedge clk);
                presc = 6'd16;
            end
        join
        bit_out(8, 1'b1, 4);

        // reset in the middle of the data bits: outputs clear, no pulse from this frame
        fork
            send(8, 9'hC3, 8, 8, 0, 0, 0, 0, 0, 0, -1, 0);
            begin
                repeat (30) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                chk("midrst_data8", 32'(p_data8), 32'h0);
                chk("midrst_flags8", {29'b0, dv8, pe8, se8}, 32'h0);
                chk("midrst_state", 32'(dut8.r_state), 32'(IDLE));
            end
        join
        lg8 = '0;
        lg5 = '0;
        rst_n = 1'b1;
        bit_out(8, 1'b1, 3);
        chk("postrst_data8", 32'(p_data8), 32'h0);
        chk("postrst_data5", 32'(p_data5), 32'h0);

        // new prescale takes effect at the next start bit
        send(8, 9'h5A, 8, 16, 0, 0, 0, 0, 0, 0, -1, 1);
        bit_out(8, 1'b1, 200);

        chk("drain8", 32'(q8.size()), 32'h0);
        chk("drain5", 32'(q5.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
